adc_frame_sched: RTL and testbench

- Sequences multi-channel ADC conversions for the three-phase FCML controller.
- Takes the ramp-compare ADC trigger level from the PWM trigger generator and decimates its rising edges.
- On each qualifying edge, runs one conversion frame: channels 0..N_CH-1 in order over a start/busy/done handshake to the ADC interface.
- Returns tagged samples, a frame-complete pulse and error flags to the control loop.

---
 rtl/fcml_adc_pkg.sv | 18 +
 rtl/adc_trig_decim.sv | 57 +++++
 rtl/adc_frame_sched.sv | 186 ++++++++++++++++++
 tb/tb_adc_frame_sched.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fcml_adc_pkg.sv
// -----------------------------------------------------------------------------
// fcml_adc_pkg
// Shared definitions for the FCML ADC frame scheduler: frame FSM state
// encoding and default sizing (three phase legs, 12-bit converter).
// -----------------------------------------------------------------------------
package fcml_adc_pkg;

    localparam int ADC_DW_DEF = 12;
    localparam int N_CH_DEF   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_FEND  = 2'd3
    } state_t;

endpackage

// File: rtl/adc_trig_decim.sv
// -----------------------------------------------------------------------------
// adc_trig_decim
// Rising-edge detector and decimator for the ramp-compare trigger level.
// Emits a one-cycle launch on every (dec_ratio+1)-th rising edge.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high clear
//   trig_in    in   trigger level, synchronous to clk
//   dec_ratio  in   DEC_W  launch every (dec_ratio+1)-th rising edge
//   launch     out  combinational one-cycle launch strobe
// -----------------------------------------------------------------------------
module adc_trig_decim #(
    parameter int DEC_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig_in,
    input  logic [DEC_W-1:0] dec_ratio,
    output logic             launch
);

    logic             trig_q;
    logic             trig_d;
    logic             trig_re;
    logic [DEC_W-1:0] dec_cnt_q;
    logic [DEC_W-1:0] dec_cnt_d;

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        trig_d    = trig_in;
        dec_cnt_d = dec_cnt_q;
        trig_re   = trig_in & ~trig_q;
        // >= rather than == so that lowering dec_ratio mid-count fires on
        // the next edge instead of wrapping the counter first.
        launch    = trig_re && (dec_cnt_q >= dec_ratio);
        if (launch) begin
            dec_cnt_d = '0;
        end else if (trig_re) begin
            dec_cnt_d = dec_cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            trig_q    <= 1'b0;
            dec_cnt_q <= '0;
        end else begin
            trig_q    <= trig_d;
            dec_cnt_q <= dec_cnt_d;
        end
    end

endmodule

// File: rtl/adc_frame_sched.sv
// -----------------------------------------------------------------------------
// adc_frame_sched
// Runs one conversion frame (channels 0..N_CH-1 in order) on each decimated
// rising edge of the PWM ramp-compare trigger, over a start/busy/done
// handshake, and returns tagged samples plus a frame-complete pulse.
//
// Optional feature: define ADC_TIMEOUT_EN to abort a frame when adc_done
// does not arrive within TIMEOUT_CYC cycles of WAIT (sets timeout_err).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   en                  enable; low acts as a synchronous soft reset
//   trig_in, dec_ratio  trigger level and decimation ratio
//   adc_busy/done/data  ADC handshake inputs
//   adc_start, adc_ch   registered start pulse and channel select
//   smp_valid/data/ch   tagged sample output
//   frame_done          pulse after the last channel's sample
//   overrun             sticky: launch arrived while a frame was active
//   timeout_err         sticky: conversion timed out (0 without the macro)
// -----------------------------------------------------------------------------
import fcml_adc_pkg::*;

module adc_frame_sched #(
    parameter int N_CH        = N_CH_DEF,
    parameter int CH_W        = 2,
    parameter int DEC_W       = 4,
    parameter int ADC_DW      = ADC_DW_DEF,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              trig_in,
    input  logic [DEC_W-1:0]  dec_ratio,
    input  logic              adc_busy,
    input  logic              adc_done,
    input  logic [ADC_DW-1:0] adc_data,
    output logic              adc_start,
    output logic [CH_W-1:0]   adc_ch,
    output logic              smp_valid,
    output logic [ADC_DW-1:0] smp_data,
    output logic [CH_W-1:0]   smp_ch,
    output logic              frame_done,
    output logic              overrun,
    output logic              timeout_err
);

    localparam int WCNT_W = $clog2(TIMEOUT_CYC + 1);

    logic soft_rst;
    logic launch;

    state_t            state_q,      state_d;
    logic [CH_W-1:0]   channel_q,    channel_d;
    logic              adc_start_q,  adc_start_d;
    logic              smp_valid_q,  smp_valid_d;
    logic [ADC_DW-1:0] smp_data_q,   smp_data_d;
    logic [CH_W-1:0]   smp_ch_q,     smp_ch_d;
    logic              frame_done_q, frame_done_d;
    logic              overrun_q,    overrun_d;

`ifdef ADC_TIMEOUT_EN
    logic [WCNT_W-1:0] wait_cnt_q,    wait_cnt_d;
    logic              timeout_err_q, timeout_err_d;
`else
    logic [WCNT_W-1:0] unused_timeout_cfg;
    assign unused_timeout_cfg = WCNT_W'(TIMEOUT_CYC);
`endif

    // en low clears everything exactly like rst, including the decimator.
    assign soft_rst = rst | ~en;

    adc_trig_decim #(
        .DEC_W (DEC_W)
    ) u_trig_decim (
        .clk       (clk),
        .rst       (soft_rst),
        .trig_in   (trig_in),
        .dec_ratio (dec_ratio),
        .launch    (launch)
    );

    always_comb begin
        state_d      = state_q;
        channel_d    = channel_q;
        adc_start_d  = 1'b0;
        smp_valid_d  = 1'b0;
        smp_data_d   = smp_data_q;
        smp_ch_d     = smp_ch_q;
        frame_done_d = 1'b0;
        // A launch outside IDLE is dropped; the running frame continues.
        overrun_d    = overrun_q | (launch && (state_q != ST_IDLE));
`ifdef ADC_TIMEOUT_EN
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = timeout_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    state_d   = ST_START;
                    channel_d = '0;
                end
            end
            ST_START: begin
                if (!adc_busy) begin
                    adc_start_d = 1'b1;
                    state_d     = ST_WAIT;
`ifdef ADC_TIMEOUT_EN
                    wait_cnt_d  = '0;
`endif
                end
            end
            ST_WAIT: begin
                // adc_done has priority over a timeout in the same cycle.
                if (adc_done) begin
                    smp_valid_d = 1'b1;
                    smp_data_d  = adc_data;
                    smp_ch_d    = channel_q;
                    if (channel_q == CH_W'(N_CH - 1)) begin
                        state_d = ST_FEND;
                    end else begin
                        channel_d = channel_q + 1'b1;
                        state_d   = ST_START;
                    end
                end
`ifdef ADC_TIMEOUT_EN
                else if (wait_cnt_q == WCNT_W'(TIMEOUT_CYC - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
`endif
            end
            ST_FEND: begin
                frame_done_d = 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (soft_rst) begin
            state_q       <= ST_IDLE;
            channel_q     <= '0;
            adc_start_q   <= 1'b0;
            smp_valid_q   <= 1'b0;
            smp_data_q    <= '0;
            smp_ch_q      <= '0;
            frame_done_q  <= 1'b0;
            overrun_q     <= 1'b0;
`ifdef ADC_TIMEOUT_EN
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            channel_q     <= channel_d;
            adc_start_q   <= adc_start_d;
            smp_valid_q   <= smp_valid_d;
            smp_data_q    <= smp_data_d;
            smp_ch_q      <= smp_ch_d;
            frame_done_q  <= frame_done_d;
            overrun_q     <= overrun_d;
`ifdef ADC_TIMEOUT_EN
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign adc_start  = adc_start_q;
    assign adc_ch     = channel_q;
    assign smp_valid  = smp_valid_q;
    assign smp_data   = smp_data_q;
    assign smp_ch     = smp_ch_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;
`ifdef ADC_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_adc_frame_sched.sv
// -----------------------------------------------------------------------------
// tb_adc_frame_sched
// Scoreboard bench: the trigger driver runs a frame-level model that decides
// which rising edges launch frames; an ADC responder answers each start and
// queues the sample it returned; a monitor pops and compares every smp_valid
// and frame_done the DUT presents.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_adc_frame_sched;

    localparam int N_CH   = 3;
    localparam int CH_W   = 2;
    localparam int DEC_W  = 4;
    localparam int ADC_DW = 12;
    localparam int TMO    = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b1;
    logic              trig_in = 1'b0;
    logic [DEC_W-1:0]  dec_ratio = '0;
    logic              adc_busy;
    logic              adc_done;
    logic [ADC_DW-1:0] adc_data;
    logic              adc_start;
    logic [CH_W-1:0]   adc_ch;
    logic              smp_valid;
    logic [ADC_DW-1:0] smp_data;
    logic [CH_W-1:0]   smp_ch;
    logic              frame_done;
    logic              overrun;
    logic              timeout_err;

    logic              busy_force = 1'b0;
    logic              rand_busy_en = 1'b0;
    logic              busy_rand = 1'b0;
    logic              resp_done = 1'b0;
    logic              man_done = 1'b0;
    logic [ADC_DW-1:0] resp_data = '0;
    logic [ADC_DW-1:0] man_data = '0;

    assign adc_busy = busy_force | (rand_busy_en & busy_rand);
    assign adc_done = resp_done | man_done;
    assign adc_data = resp_done ? resp_data : man_data;

    typedef struct {
        bit is_fd;
        int ch;
        int data;
    } exp_t;

    exp_t sb[$];
    int   exp_ch[$];

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    int frames_done = 0;
    int launches = 0;
    int cycle_no = 0;
    int start_cyc = 0;
    bit model_busy = 0;
    bit exp_overrun = 0;
    bit resp_hold = 0;
    bit fixed_mode = 0;

    adc_frame_sched #(
        .N_CH        (N_CH),
        .CH_W        (CH_W),
        .DEC_W       (DEC_W),
        .ADC_DW      (ADC_DW),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .trig_in     (trig_in),
        .dec_ratio   (dec_ratio),
        .adc_busy    (adc_busy),
        .adc_done    (adc_done),
        .adc_data    (adc_data),
        .adc_start   (adc_start),
        .adc_ch      (adc_ch),
        .smp_valid   (smp_valid),
        .smp_data    (smp_data),
        .smp_ch      (smp_ch),
        .frame_done  (frame_done),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle_no <= cycle_no + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Frame-level model: a launch happens on the (dec_ratio+1)-th rising
    // edge counted since the previous launch; it starts a frame only if none
    // is running, otherwise it is an overrun.
    task automatic model_edge();
        edge_cnt++;
        if (edge_cnt >= int'(dec_ratio) + 1) begin
            edge_cnt = 0;
            if (model_busy) begin
                exp_overrun = 1;
            end else begin
                model_busy = 1;
                launches++;
                for (int c = 0; c < N_CH; c++) exp_ch.push_back(c);
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (model_busy && n < 300) begin
            cyc();
            n++;
        end
        check("frame_completes_in_budget", 32'(model_busy), 0);
        cyc();
    endtask

    task automatic trig_edge(input int hi, input int lo, input bit wait_frame);
        trig_in = 1'b1;
        model_edge();
        repeat (hi) cyc();
        trig_in = 1'b0;
        repeat (lo) cyc();
        if (wait_frame && model_busy) wait_idle();
    endtask

    task automatic soft_reset(input bit use_en);
        if (use_en) en = 1'b0;
        else        rst = 1'b1;
        cyc();
        check("rst_adc_start",   32'(adc_start),   0);
        check("rst_adc_ch",      32'(adc_ch),      0);
        check("rst_smp_valid",   32'(smp_valid),   0);
        check("rst_smp_data",    32'(smp_data),    0);
        check("rst_smp_ch",      32'(smp_ch),      0);
        check("rst_frame_done",  32'(frame_done),  0);
        check("rst_overrun",     32'(overrun),     0);
        check("rst_timeout_err", 32'(timeout_err), 0);
        rst = 1'b0;
        en  = 1'b1;
        sb.delete();
        exp_ch.delete();
        model_busy  = 0;
        exp_overrun = 0;
        edge_cnt    = 0;
    endtask

    // Behavioural ADC: answers each start after a delay, returning data the
    // bench chose, and records what the scheduler must hand back.
    initial begin
        int   d;
        int   ch;
        exp_t e;
        forever begin
            @(negedge clk);
            if (adc_start) begin
                start_cyc = cycle_no;
                if (exp_ch.size() == 0) begin
                    check("unexpected_adc_start", 32'(adc_start), 0);
                end else begin
                    ch = exp_ch.pop_front();
                    check("adc_ch_at_start", 32'(adc_ch), 32'(ch));
                    if (!resp_hold) begin
                        d = fixed_mode ? 2 : int'($urandom_range(1, 4));
                        repeat (d - 1) @(posedge clk);
                        #1;
                        resp_data = fixed_mode ? ADC_DW'(12'h100 * (ch + 1)) : ADC_DW'($urandom);
                        resp_done = 1'b1;
                        check("adc_ch_stable_at_done", 32'(adc_ch), 32'(ch));
                        e.is_fd = 0; e.ch = ch; e.data = int'(resp_data);
                        sb.push_back(e);
                        if (ch == N_CH - 1) begin
                            e.is_fd = 1; e.ch = 0; e.data = 0;
                            sb.push_back(e);
                        end
                        @(posedge clk);
                        #1;
                        resp_done = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            busy_rand = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: compares every presented sample / frame end with the queue.
    initial begin
        exp_t e;
        bit   prev_start = 0;
        forever begin
            @(negedge clk);
            if (smp_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_smp_valid", 32'(smp_valid), 0);
                end else begin
                    e = sb.pop_front();
                    check("smp_is_sample", 32'(e.is_fd), 0);
                    check("smp_ch", 32'(smp_ch), 32'(e.ch));
                    check("smp_data", 32'(smp_data), 32'(e.data));
                end
            end
            if (frame_done) begin
                if (sb.size() == 0) begin
                    check("unexpected_frame_done", 32'(frame_done), 0);
                end else begin
                    e = sb.pop_front();
                    check("frame_done_order", 32'(e.is_fd), 1);
                    model_busy = 0;
                    frames_done++;
                end
            end
            if (prev_start) check("adc_start_back_to_back", 32'(adc_start), 0);
            prev_start = adc_start;
        end
    end

    initial begin
        int f0;
        int l0;
        int n;
        int trig_cyc;

        repeat (3) cyc();
        check("init_adc_start",   32'(adc_start),   0);
        check("init_smp_valid",   32'(smp_valid),   0);
        check("init_frame_done",  32'(frame_done),  0);
        check("init_overrun",     32'(overrun),     0);
        check("init_timeout_err", 32'(timeout_err), 0);
        rst = 1'b0;
        cyc();

        // Fixed-latency ADC, every edge launches; start latency n+2.
        fixed_mode = 1;
        dec_ratio  = 0;
        for (int k = 0; k < 2; k++) begin
            trig_cyc = cycle_no;
            trig_in  = 1'b1;
            model_edge();
            cyc();
            check("start_not_yet_at_n1", 32'(adc_start), 0);
            cyc();
            check("start_at_n2", 32'(adc_start), 1);
            trig_in = 1'b0;
            cyc();
            check("start_latency_cycles", 32'(start_cyc - trig_cyc), 2);
            wait_idle();
        end
        check("fixed_frames", 32'(frames_done), 2);
        check("no_overrun_after_fixed", 32'(overrun), 0);
        fixed_mode = 0;

        // Decimation: ratio 3 launches on edges 4 and 8.
        soft_reset(0);
        dec_ratio = 3;
        f0 = frames_done;
        for (int k = 1; k <= 8; k++) begin
            trig_edge(1, 2, 1);
            if (k == 3) check("dec_frames_after_3", 32'(frames_done - f0), 0);
            if (k == 4) check("dec_frames_after_4", 32'(frames_done - f0), 1);
            if (k == 7) check("dec_frames_after_7", 32'(frames_done - f0), 1);
        end
        check("dec_frames_after_8", 32'(frames_done - f0), 2);

        // Lowering the ratio mid-count takes effect on the next edge.
        soft_reset(0);
        dec_ratio = 3;
        f0 = frames_done;
        for (int k = 1; k <= 5; k++) trig_edge(1, 2, 1);
        check("dec_lower_before", 32'(frames_done - f0), 1);
        dec_ratio = 1;
        trig_edge(1, 2, 1);
        check("dec_lower_edge6", 32'(frames_done - f0), 2);

        // Busy held in START withholds the start pulse.
        dec_ratio  = 0;
        busy_force = 1'b1;
        trig_edge(1, 1, 0);
        for (int k = 0; k < 10; k++) begin
            check("busy_no_start", 32'(adc_start), 0);
            check("busy_adc_ch", 32'(adc_ch), 0);
            cyc();
        end
        busy_force = 1'b0;
        cyc();
        check("start_after_busy_drop", 32'(adc_start), 1);
        check("adc_ch_after_busy", 32'(adc_ch), 0);
        wait_idle();

        // Second launch edge mid-frame: overrun, frame completes untouched.
        f0 = frames_done;
        trig_edge(1, 1, 0);
        trig_edge(1, 1, 0);
        check("overrun_set", 32'(overrun), 32'(exp_overrun));
        wait_idle();
        repeat (3) cyc();
        check("overrun_sticky", 32'(overrun), 1);
        check("overrun_frame_count", 32'(frames_done - f0), 1);

        // rst, then en=0, while waiting on the ADC; a late done is ignored.
        for (int k = 0; k < 2; k++) begin
            resp_hold = 1;
            trig_edge(1, 1, 0);
            repeat (3) cyc();
            soft_reset(k == 1);
            resp_hold = 0;
            man_data  = 12'hABC;
            man_done  = 1'b1;
            cyc();
            man_done  = 1'b0;
            check("late_done_no_smp", 32'(smp_valid), 0);
            repeat (2) cyc();
            f0 = frames_done;
            trig_edge(1, 2, 1);
            check("frame_after_reset", 32'(frames_done - f0), 1);
        end

`ifdef ADC_TIMEOUT_EN
        resp_hold = 1;
        f0 = frames_done;
        trig_edge(1, 1, 0);
        n = 0;
        while (!timeout_err && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("timeout_err_set", 32'(timeout_err), 1);
        check("timeout_latency", 32'(cycle_no - start_cyc), TMO);
        exp_ch.delete();
        model_busy = 0;
        resp_hold  = 0;
        repeat (5) cyc();
        check("timeout_no_frame_done", 32'(frames_done - f0), 0);
        trig_edge(1, 2, 1);
        check("launch_after_timeout", 32'(frames_done - f0), 1);
        check("timeout_err_sticky", 32'(timeout_err), 1);
        soft_reset(0);
`else
        resp_hold = 1;
        f0 = frames_done;
        trig_edge(1, 1, 0);
        repeat (40) cyc();
        check("no_timeout_flag", 32'(timeout_err), 0);
        check("still_waiting_ch0", 32'(adc_ch), 0);
        check("no_frame_while_waiting", 32'(frames_done - f0), 0);
        soft_reset(0);
        resp_hold = 0;
`endif

        // Randomised traffic: ratios, edge shapes, ADC delays, data, busy.
        rand_busy_en = 1'b1;
        f0 = frames_done;
        l0 = launches;
        for (int k = 0; k < 30; k++) begin
            dec_ratio = DEC_W'($urandom_range(0, 3));
            trig_edge(int'($urandom_range(1, 3)), int'($urandom_range(1, 3)), 1);
        end
        rand_busy_en = 1'b0;
        repeat (4) cyc();
        check("random_frame_count", 32'(frames_done - f0), 32'(launches - l0));
        check("random_overrun", 32'(overrun), 32'(exp_overrun));
        check("scoreboard_drained", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
